// File: rtl/gx4000_pkg.sv
// Shared definitions for the GX4000 .cpr cartridge loader: parser state
// encoding, RIFF/AMS!/cb tag constants, bank geometry and the decoded
// chunk-ID payload.
package gx4000_pkg;

  localparam int unsigned BANK_SIZE   = 16384;
  localparam int unsigned BANK_OFS_W  = 14;
  localparam int unsigned BANK_NUM_W  = 5;
  localparam int unsigned BANK_CNT_W  = 6;
  localparam int unsigned MAX_BANKS   = 32;
  localparam int unsigned ADDR_W      = 23;

  localparam logic [31:0] TAG_RIFF = 32'h5249_4646;  // "RIFF"
  localparam logic [31:0] TAG_AMS  = 32'h414D_5321;  // "AMS!"
  localparam logic [15:0] TAG_CB   = 16'h6362;       // "cb"
  localparam logic [7:0]  ASCII_0  = 8'h30;
  localparam logic [7:0]  ASCII_9  = 8'h39;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHK_ID,
    ST_CHK_LEN,
    ST_DATA,
    ST_PAD,
    ST_SKIP,
    ST_DONE,
    ST_ERR
  } state_t;

  // Decoded chunk ID: valid when the ID is "cbNN" with NN in 00-31.
  typedef struct packed {
    logic                  valid;
    logic [BANK_NUM_W-1:0] num;
  } bank_id_t;

endpackage

// File: rtl/gx4000_cpr_loader.sv
// Streams an Amstrad GX4000 .cpr (RIFF/AMS!) file from the downloader and
// writes every cbNN bank chunk into SDRAM at CART_BASE + bank*16K + offset.
//
// Ports:
//   clk_sys, reset            system clock, async active-high reset
//   ioctl_download/wr/addr/dout  downloader byte stream (addr unused)
//   ioctl_wait                stall while a bank byte is being written
//   mem_addr/data/wr, mem_ack SDRAM byte write, held until acknowledged
//   load_done, load_error     parse result, valid after download falls
//   bank_count                number of completed bank chunks (sat. 32)
module gx4000_cpr_loader
  import gx4000_pkg::*;
#(
  parameter logic [22:0] CART_BASE = 23'h400000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_wr,
  input  logic                  mem_ack,
  output logic                  load_done,
  output logic                  load_error,
  output logic [BANK_CNT_W-1:0] bank_count
);

  // 4-byte tag comparator.
  function automatic logic tag_eq(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  function automatic bank_id_t parse_bank_id(input logic [31:0] id);
    bank_id_t   r;
    logic [6:0] val;
    val     = 7'(id[15:8] - ASCII_0) * 7'd10 + 7'(id[7:0] - ASCII_0);
    r.valid = (id[31:16] == TAG_CB) && is_digit(id[15:8]) && is_digit(id[7:0])
              && (val <= 7'd31);
    r.num   = BANK_NUM_W'(val);
    return r;
  endfunction

  // Outcome of a download falling edge seen in state st.
  function automatic state_t fall_eval(input state_t st, input logic at_boundary,
                                       input logic have_banks);
    if (st == ST_IDLE || st == ST_DONE || st == ST_ERR) return st;
    else if (st == ST_CHK_ID && at_boundary && have_banks) return ST_DONE;
    else return ST_ERR;
  endfunction

  state_t                state;
  logic                  dl_prev;
  logic                  fall_pending;
  logic [3:0]            byte_cnt;
  logic [23:0]           tag_sr;
  logic [23:0]           len_sr;
  logic [31:0]           len_rem;
  logic                  len_odd;
  logic                  is_bank;
  logic [BANK_NUM_W-1:0] bank;
  logic [BANK_OFS_W-1:0] offset;

  logic                  rise_c, fall_c, byte_c, ack_last_c;
  logic [31:0]           tag_c, len_c;
  bank_id_t              bank_id_c;
  state_t                ack_state_c, ev_cur_c, ev_ack_c;
  logic [BANK_CNT_W-1:0] bank_count_inc_c;
  logic                  unused_addr;

  // The stream order defines byte position; the file offset is not needed.
  assign unused_addr = ^ioctl_addr;

  assign rise_c    = ioctl_download & ~dl_prev;
  assign fall_c    = ~ioctl_download & dl_prev;
  assign byte_c    = ioctl_wr & ioctl_download;
  assign tag_c     = {tag_sr, ioctl_dout};
  assign len_c     = {ioctl_dout, len_sr};   // little-endian accumulate
  assign bank_id_c = parse_bank_id(tag_c);

  // len_rem is already decremented when the byte is accepted.
  assign ack_last_c  = (len_rem == 32'd0);
  assign ack_state_c = !ack_last_c ? ST_DATA : (len_odd ? ST_PAD : ST_CHK_ID);
  assign bank_count_inc_c = (bank_count == BANK_CNT_W'(MAX_BANKS)) ?
                            bank_count : bank_count + BANK_CNT_W'(1);

  assign ev_cur_c = fall_eval(state, byte_cnt == 4'd0, bank_count != '0);
  assign ev_ack_c = fall_eval(ack_state_c, 1'b1, ack_last_c | (bank_count != '0));

  // Parser state machine with registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      dl_prev      <= 1'b0;
      fall_pending <= 1'b0;
      byte_cnt     <= '0;
      tag_sr       <= '0;
      len_sr       <= '0;
      len_rem      <= '0;
      len_odd      <= 1'b0;
      is_bank      <= 1'b0;
      bank         <= '0;
      offset       <= '0;
      ioctl_wait   <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_wr       <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      bank_count   <= '0;
    end else begin
      dl_prev <= ioctl_download;
      if (rise_c) begin
        state        <= ST_HDR;
        fall_pending <= 1'b0;
        byte_cnt     <= '0;
        tag_sr       <= '0;
        len_sr       <= '0;
        len_rem      <= '0;
        len_odd      <= 1'b0;
        is_bank      <= 1'b0;
        bank         <= '0;
        offset       <= '0;
        ioctl_wait   <= 1'b0;
        mem_wr       <= 1'b0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        bank_count   <= '0;
      end else if (mem_wr) begin
        // Outstanding write: only the acknowledge (or a deferred fall) matters.
        if (mem_ack) begin
          mem_wr     <= 1'b0;
          ioctl_wait <= 1'b0;
          if (ack_last_c) bank_count <= bank_count_inc_c;
          if (fall_pending || fall_c) begin
            fall_pending <= 1'b0;
            state        <= ev_ack_c;
            if (ev_ack_c == ST_DONE) load_done <= 1'b1;
            if (ev_ack_c == ST_ERR) load_error <= 1'b1;
          end else begin
            state <= ack_state_c;
          end
        end else if (fall_c) begin
          fall_pending <= 1'b1;
        end
      end else if (fall_c || fall_pending) begin
        fall_pending <= 1'b0;
        state        <= ev_cur_c;
        if (ev_cur_c == ST_DONE) load_done <= 1'b1;
        if (ev_cur_c == ST_ERR) load_error <= 1'b1;
      end else if (byte_c) begin
        case (state)
          ST_HDR: begin
            tag_sr   <= tag_c[23:0];
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd3 && !tag_eq(tag_c, TAG_RIFF)) begin
              state      <= ST_ERR;
              load_error <= 1'b1;
            end else if (byte_cnt == 4'd11) begin
              byte_cnt <= '0;
              if (tag_eq(tag_c, TAG_AMS)) begin
                state <= ST_CHK_ID;
              end else begin
                state      <= ST_ERR;
                load_error <= 1'b1;
              end
            end
          end
          ST_CHK_ID: begin
            tag_sr <= tag_c[23:0];
            if (byte_cnt == 4'd3) begin
              byte_cnt <= '0;
              is_bank  <= bank_id_c.valid;
              bank     <= bank_id_c.num;
              state    <= ST_CHK_LEN;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
          ST_CHK_LEN: begin
            len_sr <= len_c[31:8];
            if (byte_cnt == 4'd3) begin
              byte_cnt <= '0;
              len_rem  <= len_c;
              len_odd  <= len_c[0];
              offset   <= '0;
              if (len_c == 32'd0) begin
                state <= ST_CHK_ID;
              end else if (!is_bank) begin
                state <= ST_SKIP;
              end else if (len_c > BANK_SIZE) begin
                state      <= ST_ERR;
                load_error <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
          ST_DATA: begin
            mem_wr     <= 1'b1;
            ioctl_wait <= 1'b1;
            mem_addr   <= CART_BASE + ADDR_W'({bank, offset});
            mem_data   <= ioctl_dout;
            offset     <= offset + BANK_OFS_W'(1);
            len_rem    <= len_rem - 32'd1;
          end
          ST_SKIP: begin
            len_rem <= len_rem - 32'd1;
            if (len_rem == 32'd1) state <= len_odd ? ST_PAD : ST_CHK_ID;
          end
          ST_PAD: begin
            state <= ST_CHK_ID;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// Self-checking bench for gx4000_cpr_loader: builds .cpr byte streams,
// predicts writes/result with a software parser, and compares.
module tb_gx4000_cpr_loader;

  localparam logic [22:0] BASE = 23'h400000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, ioctl_wait;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [22:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr, mem_ack, load_done, load_error;
  logic [5:0]  bank_count;

  always #5 clk_sys = ~clk_sys;

  gx4000_cpr_loader #(.CART_BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .load_done(load_done), .load_error(load_error), .bank_count(bank_count)
  );

  int unsigned n_cmp = 0, n_bad = 0;
  logic [7:0]  file_q[$];
  logic [22:0] exp_addr[$], got_addr[$];
  logic [7:0]  exp_data[$], got_data[$];
  int unsigned wait_q[$];
  logic        exp_done, exp_err;
  int unsigned exp_banks;
  int unsigned unstable, proto_bad, wait_bad, timeouts;
  int unsigned ack_delay = 2, delay_max = 0;
  logic        rand_delay = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: acks after a chosen delay, records writes, watches stability.
  initial begin
    logic        in_txn, acked;
    int unsigned cnt, cur_d, run_wait;
    logic [22:0] ta;
    logic [7:0]  td;
    in_txn = 0; acked = 0; cnt = 0; cur_d = 0; run_wait = 0; ta = '0; td = '0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      mem_ack = 1'b0;
      if (reset) begin
        in_txn = 0; acked = 0;
      end else if (mem_wr && acked) begin
        proto_bad++;
      end else if (mem_wr) begin
        if (!in_txn) begin
          in_txn = 1; cnt = 0; run_wait = 0;
          cur_d = rand_delay ? $urandom_range(delay_max, 0) : ack_delay;
          ta = mem_addr; td = mem_data;
          got_addr.push_back(ta); got_data.push_back(td);
        end else if (mem_addr !== ta || mem_data !== td) begin
          unstable++;
        end
        if (ioctl_wait) run_wait++;
        if (cnt == cur_d) begin mem_ack = 1'b1; acked = 1; end
        else cnt++;
      end else begin
        if (in_txn) begin
          wait_q.push_back(run_wait);
          if (run_wait != cur_d + 1) wait_bad++;
          in_txn = 0;
        end
        acked = 0;
        if (ioctl_wait) proto_bad++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- file construction ----------------
  task automatic add_w(input logic [31:0] w);
    file_q.push_back(w[31:24]); file_q.push_back(w[23:16]);
    file_q.push_back(w[15:8]);  file_q.push_back(w[7:0]);
  endtask

  task automatic add_le(input logic [31:0] v);
    file_q.push_back(v[7:0]);   file_q.push_back(v[15:8]);
    file_q.push_back(v[23:16]); file_q.push_back(v[31:24]);
  endtask

  task automatic add_hdr(input logic [31:0] form);
    file_q.delete();
    add_w("RIFF"); add_le($urandom); add_w(form);
  endtask

  task automatic add_chunk(input logic [31:0] id, input int unsigned len, input logic body);
    add_w(id); add_le(len);
    if (body) begin
      for (int unsigned i = 0; i < len; i++) file_q.push_back(8'($urandom));
      if (len % 2 == 1) file_q.push_back(8'h00);
    end
  endtask

  // ---------------- reference parser ----------------
  function automatic logic [31:0] word_at(input int p);
    return {file_q[p], file_q[p+1], file_q[p+2], file_q[p+3]};
  endfunction

  task automatic model_parse();
    int          n, pos, bnum;
    logic        err;
    logic [31:0] id, len;
    logic        bank_ok;
    n = file_q.size(); err = 0; exp_banks = 0; pos = 12;
    exp_addr.delete(); exp_data.delete();
    if (n < 12) err = 1;
    else if (word_at(0) != "RIFF" || word_at(8) != "AMS!") err = 1;
    while (!err && pos < n) begin
      if (n - pos < 8) begin err = 1; break; end
      id  = word_at(pos);
      len = {file_q[pos+7], file_q[pos+6], file_q[pos+5], file_q[pos+4]};
      pos += 8;
      bnum = (int'(id[15:8]) - 48) * 10 + (int'(id[7:0]) - 48);
      bank_ok = id[31:16] == "cb" && id[15:8] >= "0" && id[15:8] <= "9" &&
                id[7:0] >= "0" && id[7:0] <= "9" && bnum <= 31;
      if (bank_ok && len > 16384) begin err = 1; break; end
      if (bank_ok) begin
        for (int j = 0; j < int'(len); j++)
          if (pos + j < n) begin
            exp_addr.push_back(23'(int'(BASE) + bnum * 16384 + j));
            exp_data.push_back(file_q[pos+j]);
          end
        if (len > 0 && pos + int'(len) <= n && exp_banks < 32) exp_banks++;
      end
      pos += int'(len) + int'(len % 2);
      if (pos > n) err = 1;
    end
    exp_err  = err || exp_banks == 0;
    exp_done = !exp_err;
  endtask

  // ---------------- driver ----------------
  task automatic start_dl();
    unstable = 0; proto_bad = 0; wait_bad = 0; timeouts = 0;
    got_addr.delete(); got_data.delete(); wait_q.delete();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic send_bytes(input int count, input int gap_max, input int inject_idx);
    for (int i = 0; i < count; i++) begin
      int guard = 0;
      while (ioctl_wait && guard < 500) begin @(posedge clk_sys); #1; guard++; end
      if (guard >= 500) timeouts++;
      ioctl_wr = 1'b1; ioctl_dout = file_q[i]; ioctl_addr = 25'(i);
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      if (i == inject_idx) begin
        ioctl_wr = 1'b1; ioctl_dout = 8'hEE;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
      end
      repeat ($urandom_range(gap_max, 0)) @(posedge clk_sys);
      #0;
    end
  endtask

  task automatic end_dl();
    int guard = 0;
    ioctl_download = 1'b0;
    while (!(!mem_wr && (load_done || load_error)) && guard < 100) begin
      @(posedge clk_sys); #1; guard++;
    end
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_result(input string name);
    int unsigned bad = 0;
    chk({name, " load_done"}, 64'(load_done), 64'(exp_done));
    chk({name, " load_error"}, 64'(load_error), 64'(exp_err));
    chk({name, " bank_count"}, 64'(bank_count), 64'(exp_banks));
    chk({name, " write_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) bad++;
    chk({name, " write_content_errs"}, 64'(bad), 64'd0);
    chk({name, " unstable_cycles"}, 64'(unstable), 64'd0);
    chk({name, " protocol_errs"}, 64'(proto_bad + wait_bad + timeouts), 64'd0);
  endtask

  task automatic run_file(input string name, input int gap_max, input int inject_idx);
    model_parse();
    start_dl();
    send_bytes(file_q.size(), gap_max, inject_idx);
    end_dl();
    check_result(name);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset mem_wr", 64'(mem_wr), 64'd0);
    chk("reset outputs", 64'({ioctl_wait, load_done, load_error, bank_count, mem_addr, mem_data}), 64'd0);
    reset = 1'b0;
    @(posedge clk_sys); #1;
    chk("idle outputs", 64'({mem_wr, ioctl_wait, load_done, load_error, bank_count}), 64'd0);

    // Valid file: 16K bank 0 then 3-byte bank 1, ack two cycles after mem_wr.
    ack_delay = 2; rand_delay = 0;
    add_hdr("AMS!"); add_chunk("cb00", 16384, 1); add_chunk("cb01", 3, 1);
    run_file("valid", 0, -1);
    chk("valid total writes", 64'(got_addr.size()), 64'd16387);
    chk("valid addr -3", 64'(got_addr[got_addr.size()-3]), 64'h404000);
    chk("valid addr -1", 64'(got_addr[got_addr.size()-1]), 64'h404002);
    chk("valid done", 64'({load_done, bank_count}), 64'({1'b1, 6'd2}));

    // Bad form type.
    add_hdr("AMS?"); add_chunk("cb00", 4, 1);
    run_file("bad_form", 1, -1);
    chk("bad_form error/writes", 64'({load_error, 8'(got_addr.size())}), 64'({1'b1, 8'd0}));

    // Unknown chunk skipped (5 bytes + pad) then one-byte bank 2.
    add_hdr("AMS!"); add_chunk("fmt ", 5, 1); add_chunk("cb02", 1, 1);
    run_file("skip", 1, -1);
    chk("skip single addr", 64'(got_addr[0]), 64'h408000);

    // Oversized bank: error as soon as the length field completes.
    add_hdr("AMS!"); add_chunk("cb03", 16385, 0);
    model_parse();
    start_dl();
    send_bytes(file_q.size(), 0, -1);
    repeat (2) @(posedge clk_sys);
    #1;
    chk("oversize error before fall", 64'(load_error), 64'd1);
    end_dl();
    check_result("oversize");

    // Withheld acknowledge: ioctl_wait spans 11 cycles, write held stable.
    ack_delay = 10;
    add_hdr("AMS!"); add_chunk("cb04", 2, 1);
    run_file("slow_ack", 0, -1);
    chk("slow_ack wait cycles", 64'(wait_q[0]), 64'd11);
    chk("slow_ack addr", 64'(got_addr[1]), 64'h410001);

    // Strobe during an outstanding write is dropped.
    ack_delay = 3;
    add_hdr("AMS!"); add_chunk("cb07", 3, 1);
    run_file("violation", 0, 20);

    // Reset in the middle of a bank write.
    ack_delay = 50;
    add_hdr("AMS!"); add_chunk("cb05", 4, 1);
    start_dl();
    send_bytes(22, 0, -1);
    chk("pre-reset mem_wr", 64'(mem_wr), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset mem_wr/wait", 64'({mem_wr, ioctl_wait}), 64'd0);
    chk("async reset addr/data", 64'({mem_addr, mem_data}), 64'd0);
    chk("async reset status", 64'({load_done, load_error, bank_count}), 64'd0);
    @(posedge clk_sys); #1;
    reset = 1'b0; ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    ack_delay = 1;
    add_hdr("AMS!"); add_chunk("cb05", 4, 1); add_chunk("cb31", 5, 1);
    run_file("after_reset", 1, -1);

    // Randomized files: valid/invalid chunk IDs, random lengths, truncation.
    rand_delay = 1; delay_max = 3;
    for (int t = 0; t < 6; t++) begin
      int nch;
      add_hdr("AMS!");
      nch = $urandom_range(4, 1);
      for (int c = 0; c < nch; c++) begin
        int unsigned k, b;
        logic [31:0] id;
        k = $urandom_range(4, 0);
        b = $urandom_range(31, 0);
        id = {"cb", 8'(8'h30 + b / 10), 8'(8'h30 + b % 10)};
        case (k)
          1: id = "fmt ";
          2: id = "cb45";
          3: id = "cb7x";
          default: ;
        endcase
        add_chunk(id, $urandom_range(12, 0), 1);
      end
      if ($urandom_range(3, 0) == 0)
        repeat ($urandom_range(5, 1)) void'(file_q.pop_back());
      run_file($sformatf("random%0d", t), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gx4000_cpr_loader.md
GX4000_CPR_LOADER -- requirements
Module: gx4000_cpr_loader

Interface
REQ-001 SHALL have parameter CART_BASE, default 23'h400000, SDRAM byte address of cartridge bank 0.
REQ-002 SHALL have ports, clock and reset first:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  high for the whole .cpr file transfer
- ioctl_wr  in  1  one-cycle strobe, byte valid
- ioctl_addr  in  25  file byte offset
- ioctl_dout  in  8  file byte
- ioctl_wait  out  1  stall request to the downloader
- mem_addr  out  23  SDRAM byte address
- mem_data  out  8  SDRAM write byte
- mem_wr  out  1  write request, held until acknowledged
- mem_ack  in  1  one-cycle write acknowledge
- load_done  out  1  file parsed successfully
- load_error  out  1  malformed file
- bank_count  out  6  number of cbNN chunks written

Function
REQ-003 SHALL start parsing on the rising edge of ioctl_download: clear counters, load_done and load_error; enter HDR.
REQ-004 SHALL consume bytes only on ioctl_wr while ioctl_download is high; ioctl_addr is ignored and the byte order is the stream order.
REQ-005 SHALL check header bytes 0-3 = "RIFF" and 8-11 = "AMS!" (bytes 4-7 ignored); any mismatch -> ERR.
REQ-006 SHALL implement states IDLE, HDR, CHK_ID (4 bytes), CHK_LEN (4 bytes, little-endian, 32-bit), DATA, PAD, SKIP, DONE, ERR.
REQ-007 SHALL accept as a bank chunk an ID of "cb" followed by two ASCII decimal digits with value 00-31; the bank number is 10*d1+d0.
REQ-008 SHALL pass a bank chunk with length 1-16384 to DATA; length 0 goes straight back to CHK_ID (PAD first if odd, never applicable for 0).
REQ-009 SHALL route a bank chunk with length >16384 to ERR.
REQ-010 SHALL route any other chunk ID through SKIP for length bytes, then PAD if the length is odd, then CHK_ID.
REQ-011 SHALL issue, in DATA, one write per byte: mem_addr = CART_BASE + {bank[4:0], offset[13:0]}, offset counting from 0.
REQ-012 SHALL present mem_wr, mem_addr and mem_data on the cycle after the ioctl_wr strobe and hold them stable until the mem_ack cycle; mem_wr drops the cycle after mem_ack.
REQ-013 SHALL drive ioctl_wait high from the cycle after a DATA byte is accepted until the cycle after mem_ack; non-DATA bytes never assert ioctl_wait.
REQ-014 SHALL ignore an ioctl_wr arriving while a write is outstanding (downloader protocol violation) and leave state unchanged.
REQ-015 SHALL, after the last DATA byte is acknowledged, increment bank_count (saturating at 32), then enter PAD if the length is odd, else CHK_ID; the PAD byte is discarded.
REQ-016 SHALL, on the falling edge of ioctl_download, set load_done=1 and enter DONE if in CHK_ID with zero ID bytes consumed and bank_count>0; otherwise set load_error=1 and enter ERR.
REQ-017 SHALL, if ioctl_download falls with a write outstanding, complete that write (wait for mem_ack) before the REQ-016 evaluation.
REQ-018 SHALL make ERR and DONE absorbing until the next rising edge of ioctl_download; in ERR no further mem_wr is issued.
REQ-019 SHALL ignore mem_ack when no write is outstanding.

Reset
REQ-020 SHALL, on reset, force state IDLE, ioctl_wait=0, mem_wr=0, mem_addr=0, mem_data=0, load_done=0, load_error=0, bank_count=0, all byte and length counters 0.
REQ-021 SHALL, on reset during an outstanding write, drop mem_wr immediately with no acknowledge wait.

Structure
REQ-022 SHALL place the state encoding, the RIFF/AMS!/cb ASCII constants and the 16384 bank size in shared package gx4000_pkg.
REQ-023 SHALL be a single module with no sub-modules; the 4-byte tag comparator is an internal function, not a separate block.

Verification
REQ-024 SHALL verify a valid file (header, cb00 length 16384, cb01 length 3) with mem_ack 2 cycles after mem_wr -> 16387 writes; last writes go to 0x404000-0x404002; load_done=1; bank_count=2.
REQ-025 SHALL verify a header with "AMS?" at bytes 8-11 -> load_error=1 and zero mem_wr pulses.
REQ-026 SHALL verify an unknown chunk "fmt " of length 5 followed by cb02 of length 1 -> 6 bytes skipped; a single write to 0x408000.
REQ-027 SHALL verify a cb03 chunk of length 16385 -> load_error=1 after the length field; no writes.
REQ-028 SHALL verify mem_ack withheld for 10 cycles -> ioctl_wait stays high for 11 cycles; mem_addr and mem_data are stable throughout.
REQ-029 SHALL verify reset asserted mid-DATA with mem_wr high -> all outputs reach reset values asynchronously; a following download parses correctly.
